// File: rtl/array_stream_reader.sv
// Streams RAM words 0..last (inclusive) out on a valid/ready interface through a 2-entry buffer.
// Optional feature macro SIZE_HEADER_EN: prefixes each pass with a header beat carrying `last`.
module array_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [WORD_SIZE-1:0]  rdata,
  output logic [WORD_SIZE-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_HDR   | pushing the size header beat (SIZE_HEADER_EN only)
  // S_READ  | issuing RAM reads while credit allows
  // S_DRAIN | all reads issued; waiting for buffer and in-flight read to empty
`ifdef SIZE_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_READ, S_DRAIN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
`endif

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  inflight, inflight_last;
  logic [WORD_SIZE-1:0]  buf_data [2];
  logic                  buf_last [2];
  logic [1:0]            buf_cnt;
  logic [1:0]            cnt;
  logic                  pop, credit, hdr_push, push, push_last;
  logic [WORD_SIZE-1:0]  push_data;

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_data[0];
  assign out_last  = out_valid && buf_last[0];
  assign pop       = out_valid && out_ready;
  assign cnt       = buf_cnt + {1'b0, inflight};
  // A full pipeline may still accept a new entry when a beat leaves in the same cycle.
  assign credit    = (cnt != 2'd2) || pop;

`ifdef SIZE_HEADER_EN
  logic [WORD_SIZE-1:0] hdr_word;

  generate
    if (WORD_SIZE < ADDR_WIDTH) begin : g_hdr_width_check
      $error("array_stream_reader: WORD_SIZE must be >= ADDR_WIDTH when SIZE_HEADER_EN is defined");
    end
  endgenerate

  always_comb begin
    hdr_word = '0;
    hdr_word[ADDR_WIDTH-1:0] = last_q;
  end

  assign push_data = inflight ? rdata : hdr_word;
`else
  assign push_data = rdata;
`endif

  assign push      = inflight || hdr_push;
  assign push_last = inflight && inflight_last;

  always_comb begin
    state_nxt = state;
    re        = 1'b0;
    hdr_push  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef SIZE_HEADER_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_READ;
`endif
        end
      end
`ifdef SIZE_HEADER_EN
      S_HDR: begin
        if (credit) begin
          hdr_push  = 1'b1;
          state_nxt = S_READ;
        end
      end
`endif
      S_READ: begin
        re = credit;
        if (credit && (raddr == last_q)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((buf_cnt == 2'd0) && !inflight) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // busy falls together with the done pulse, while the state still blocks a new start.
  assign busy = (state != S_IDLE) && !done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      last_q        <= '0;
      raddr         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      buf_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      state         <= state_nxt;
      inflight      <= re;
      inflight_last <= re && (raddr == last_q);

      if ((state == S_IDLE) && start) begin
        last_q <= length;
        raddr  <= '0;
      end else if (re) begin
        raddr  <= raddr + ADDR_WIDTH'(1);
      end

      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) begin
            buf_data[0] <= push_data;
            buf_last[0] <= push_last;
          end else begin
            buf_data[1] <= push_data;
            buf_last[1] <= push_last;
          end
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_data[0] <= push_data;
            buf_last[0] <= push_last;
          end else begin
            buf_data[0] <= buf_data[1];
            buf_last[0] <= buf_last[1];
            buf_data[1] <= push_data;
            buf_last[1] <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_stream_reader.sv
// Directed bench for array_stream_reader (ADDR_WIDTH=4): vector table of passes plus
// hand-written latency, start-during-done and mid-pass reset sequences.
module tb_array_stream_reader;

  localparam int AW = 4;
  localparam int WS = 16;
`ifdef SIZE_HEADER_EN
  localparam int HB = 1;
`else
  localparam int HB = 0;
`endif

  logic          clk;
  logic          resetn;
  logic          start;
  logic [AW-1:0] length;
  logic          re;
  logic [AW-1:0] raddr;
  logic [WS-1:0] rdata;
  logic [WS-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  array_stream_reader #(.ADDR_WIDTH(AW), .WORD_SIZE(WS)) dut (
    .clk(clk), .resetn(resetn), .start(start), .length(length),
    .re(re), .raddr(raddr), .rdata(rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WS-1:0] ram [1<<AW];
  always @(posedge clk) if (re) rdata <= ram[raddr];

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: captures beats and read addresses, checks hold-while-stalled and credit use.
  logic [WS:0]   got_q [$];
  logic [AW-1:0] raddr_q [$];
  int            issued = 0, popped = 0, done_cnt = 0, cyc = 0, last_xfer_cyc = -10;
  logic          prev_stall = 1'b0, prev_last = 1'b0, prev_busy = 1'b0;
  logic [WS-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (re) begin
        check("credit_ok", 32'((issued - popped == 2) && !(out_valid && out_ready)), 32'd0);
        raddr_q.push_back(raddr);
        issued++;
      end
`ifdef SIZE_HEADER_EN
      if (busy && !prev_busy) issued++;
`endif
      if (out_valid && out_ready) begin
        got_q.push_back({out_last, out_data});
        popped++;
        if (out_last) last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_busy  = busy;
    end
  end

  logic [15:0] lfsr = 16'hACE1;
  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      return lfsr[0];
    end
    if (mode == 2) return (c % 2) == 0;
    return 1'b1;
  endfunction

  // One full pass; expects beats built from the bench RAM image.
  task automatic run_pass(input int len, input int mode, input int poke, input int exp_beats);
    logic [WS:0] exp_q [$];
    int c;
    got_q.delete();
    raddr_q.delete();
    done_cnt = 0;
`ifdef SIZE_HEADER_EN
    exp_q.push_back({1'b0, WS'(len)});
`endif
    for (int i = 0; i <= len; i++) exp_q.push_back({(i == len), ram[i]});
    start     = 1'b1;
    length    = AW'(len);
    out_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (done_cnt == 0 && c < 300) begin
      out_ready = ready_for(mode, c);
      if (poke != 0 && c == 3) begin
        start  = 1'b1;
        length = AW'(9);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pass_done_count", 32'(done_cnt), 32'd1);
    check("pass_beats", 32'(got_q.size()), 32'(exp_beats));
    check("pass_exp_len", 32'(exp_q.size()), 32'(exp_beats));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("pass_beat", 32'(got_q[i]), 32'(exp_q[i]));
    check("pass_reads", 32'(raddr_q.size()), 32'(len + 1));
    for (int i = 0; i < raddr_q.size() && i <= len; i++)
      check("pass_raddr", 32'(raddr_q[i]), 32'(i));
    check("pass_idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int len;
    int mode;
    int poke;
    int exp_beats;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{len: 3,  mode: 0, poke: 0, exp_beats: 4  + HB};
    vecs[1] = '{len: 0,  mode: 0, poke: 0, exp_beats: 1  + HB};
    vecs[2] = '{len: 5,  mode: 1, poke: 0, exp_beats: 6  + HB};
    vecs[3] = '{len: 15, mode: 0, poke: 0, exp_beats: 16 + HB};
    vecs[4] = '{len: 15, mode: 1, poke: 0, exp_beats: 16 + HB};
    vecs[5] = '{len: 7,  mode: 2, poke: 0, exp_beats: 8  + HB};
    vecs[6] = '{len: 4,  mode: 2, poke: 1, exp_beats: 5  + HB};

    for (int i = 0; i < (1 << AW); i++) ram[i] = WS'(i + 100);
    resetn = 1'b0; start = 1'b0; length = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_re", 32'(re), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Latency, consecutive beats, and start coincident with done.
    out_ready = 1'b1; start = 1'b1; length = AW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("lat_re_first", 32'(re), 32'(HB == 0));
    check("lat_valid_first", 32'(out_valid), 32'd0);
    check("lat_busy", 32'(busy), 32'd1);
`ifdef SIZE_HEADER_EN
    @(negedge clk);
    check("hdr_valid", 32'(out_valid), 32'd1);
    check("hdr_data", 32'(out_data), 32'd3);
    check("hdr_last", 32'(out_last), 32'd0);
    check("hdr_re", 32'(re), 32'd1);
`endif
    @(negedge clk);
    check("lat_valid_gap", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_data", 32'(out_data), 32'(k + 100));
      check("seq_last", 32'(out_last), 32'(k == 3));
    end
    @(posedge clk); #1;
    start = 1'b1; length = AW'(2);
    @(negedge clk);
    check("seq_done", 32'(done), 32'd1);
    check("seq_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_start_busy", 32'(busy), 32'd0);
    check("ign_start_re", 32'(re), 32'd0);
    check("ign_start_done", 32'(done), 32'd0);
    @(negedge clk);
    check("ign_start_busy2", 32'(busy), 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++)
      run_pass(vecs[v].len, vecs[v].mode, vecs[v].poke, vecs[v].exp_beats);

    // Reset in the middle of a stalled pass.
    done_cnt = 0;
    out_ready = 1'b0; start = 1'b1; length = AW'(7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_valid_before", 32'(out_valid), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_re", 32'(re), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < (1 << AW); i++) ram[i] = WS'(i + 200);
    run_pass(1, 0, 0, 2 + HB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
